// File: rtl/uart_pkg.sv
// Shared definitions for the UART baud-rate generator and the UART register
// block.
//   MIN_DIV_INT  : smallest legal integer divisor. A period of one clock
//                  would leave no idle cycle between sample ticks.
//   baud_div_t   : register-block view of a divisor {div_int, div_frac} at
//                  the default widths. The generator ports carry the same
//                  {int, frac} packing.
//   def_div_int  : integer part of CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE).
//   def_div_frac : fractional part of the same ratio, in units of
//                  1/2^frac_w.
package uart_pkg;

  localparam int MIN_DIV_INT = 2;

  localparam int BAUD_DIV_W  = 16;
  localparam int BAUD_FRAC_W = 4;

  typedef struct packed {
    logic [BAUD_DIV_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
  } baud_div_t;

  function automatic int unsigned def_div_int(input int unsigned clock_freq,
                                              input int unsigned baud_rate,
                                              input int unsigned oversample);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clock_freq);
    den = 64'(baud_rate) * 64'(oversample);
    return 32'(num / den);
  endfunction

  function automatic int unsigned def_div_frac(input int unsigned clock_freq,
                                               input int unsigned baud_rate,
                                               input int unsigned oversample,
                                               input int unsigned frac_w);
    longint unsigned num;
    longint unsigned den;
    num = 64'(clock_freq) << frac_w;
    den = 64'(baud_rate) * 64'(oversample);
    return 32'((num / den) % (64'd1 << frac_w));
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_div.sv
// Fractional sample-tick divider (frac_tick_div).
// Each sample period is div_int or div_int+1 clocks. The extra clock is taken
// when the fractional accumulator overflows, so the long-run mean period is
// div_int + div_frac/2^FRAC_W.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   en           : low clears the counter, the accumulator and the tick
//   restart      : with en high, abandons the current period and starts a
//                  new one with the accumulator at zero
//   div          : {div_int, div_frac} used at each period start
//   start        : (comb) this edge begins a period and samples div
//   tick_fire    : (comb) this edge sets sample_tick
//   sample_tick  : registered one-cycle tick at the end of each period
module frac_tick_div #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    restart,
  input  logic [DIV_W+FRAC_W-1:0] div,
  output logic                    start,
  output logic                    tick_fire,
  output logic                    sample_tick
);

  localparam logic [DIV_W:0] CNT_ONE = (DIV_W+1)'(1);

  // cnt holds the edges still to come up to and including the tick edge.
  // It is one bit wider than div_int so that div_int + carry fits.
  logic [DIV_W:0]    cnt;
  logic [FRAC_W-1:0] frac_acc;
  logic              running;

  logic [FRAC_W-1:0] acc_base;
  logic [FRAC_W:0]   acc_sum;
  logic [DIV_W:0]    period;

  always_comb begin
    // The edge after a tick is edge 1 of the next period. This keeps the
    // tick edge and the divisor-sampling edge one cycle apart, so a divisor
    // swapped in at the boundary is already stable when it is sampled.
    start     = en && (!running || restart || sample_tick);
    tick_fire = en && !start && (cnt == CNT_ONE);
    acc_base  = restart ? '0 : frac_acc;
    acc_sum   = {1'b0, acc_base} + {1'b0, div[FRAC_W-1:0]};
    period    = {1'b0, div[DIV_W+FRAC_W-1:FRAC_W]}
              + {{DIV_W{1'b0}}, acc_sum[FRAC_W]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frac_acc    <= '0;
      running     <= 1'b0;
      sample_tick <= 1'b0;
    end else if (!en) begin
      cnt         <= '0;
      frac_acc    <= '0;
      running     <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      running     <= 1'b1;
      sample_tick <= tick_fire;
      if (start) begin
        // This edge is edge 1 of the period, so period-1 edges remain.
        cnt      <= period - CNT_ONE;
        frac_acc <= acc_sum[FRAC_W-1:0];
      end else if (cnt != '0) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Runtime-programmable fractional baud-rate generator.
// Produces the oversample tick, a bit tick on the last sample of each bit, and
// a mid tick on sample OVERSAMPLE/2 of each bit.
// Ports:
//   clk, rst_n             : clock and asynchronous active-low reset
//   en                     : low holds all counters cleared
//   sync_clr               : restart pulse used to align to a start bit
//   cfg_valid / cfg_ready  : divisor handshake
//   cfg_div_int/_frac      : offered divisor, integer and fractional parts
//   cfg_err                : one-cycle pulse after an illegal divisor
//                            transfer
//   sample_tick, bit_tick,
//   mid_tick               : registered one-cycle tick outputs
//
// Config handshake: a transfer happens on a clock edge where cfg_valid and
// cfg_ready are both high. The source holds cfg_valid and the data stable
// until that edge. A legal divisor goes into the shadow register, and
// cfg_ready stays low until the shadow has been promoted at a period boundary.
// An illegal divisor (div_int below MIN_DIV_INT) is consumed and discarded,
// and cfg_ready stays high.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int          DIV_W      = 16,
  parameter int          FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DIV_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  output logic              cfg_err,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam int unsigned       DEF_INT_U  = def_div_int(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned       DEF_FRAC_U = def_div_frac(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE,
                                                          FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT    = DIV_W'(DEF_INT_U);
  localparam logic [FRAC_W-1:0] DEF_FRAC   = FRAC_W'(DEF_FRAC_U);
  localparam logic [DIV_W-1:0]  MIN_INT    = DIV_W'(MIN_DIV_INT);

  localparam int                OS_W       = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]   OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_PRE_MID = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]   OS_ONE     = OS_W'(1);

  logic [DIV_W-1:0]        act_int;
  logic [FRAC_W-1:0]       act_frac;
  logic [DIV_W-1:0]        shd_int;
  logic [FRAC_W-1:0]       shd_frac;
  logic [OS_W-1:0]         os_cnt;

  logic                    pending;
  logic                    xfer;
  logic                    cfg_legal;
  logic                    apply;
  logic                    start;
  logic                    tick_fire;
  logic [DIV_W+FRAC_W-1:0] div_eff;

  always_comb begin
    // cfg_ready is the inverse of the shadow-full flag.
    pending   = !cfg_ready;
    xfer      = cfg_valid && cfg_ready;
    cfg_legal = (cfg_div_int >= MIN_INT);
    // Promote the shadow at a period start or at any time while disabled.
    apply     = pending && (!en || start);
    // A period that starts on the promotion edge must already use the new
    // divisor, so the shadow is forwarded while it is pending.
    div_eff   = pending ? {shd_int, shd_frac} : {act_int, act_frac};
  end

  frac_tick_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_tick_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .restart     (sync_clr),
    .div         (div_eff),
    .start       (start),
    .tick_fire   (tick_fire),
    .sample_tick (sample_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int   <= DEF_INT;
      act_frac  <= DEF_FRAC;
      shd_int   <= '0;
      shd_frac  <= '0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= xfer && !cfg_legal;
      if (apply) begin
        act_int   <= shd_int;
        act_frac  <= shd_frac;
        cfg_ready <= 1'b1;
      end else if (xfer && cfg_legal) begin
        shd_int   <= cfg_div_int;
        shd_frac  <= cfg_div_frac;
        cfg_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      os_cnt   <= '0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else if (!en || sync_clr) begin
      os_cnt   <= '0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else if (tick_fire) begin
      os_cnt   <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_ONE;
      bit_tick <= (os_cnt == OS_LAST);
      mid_tick <= (os_cnt == OS_PRE_MID);
    end else begin
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac.
// Expected tick times come from a closed-form model. After n periods that
// start from accumulator value a, the n-th tick sits at
// base + n*div_int + floor((a + n*div_frac) / 2^FRAC_W).
// Here base is the last edge before edge 1 of the segment.
module tb_uart_baud_gen_frac;
  import uart_pkg::*;

  localparam int OS       = 16;
  localparam int FRAC_ONE = 16;

  logic        clk;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        sync_clr = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_div_int = '0;
  logic [3:0]  cfg_div_frac = '0;
  logic        cfg_err;
  logic        sample_tick;
  logic        bit_tick;
  logic        mid_tick;

  // Narrow instance used only for the full-width period check.
  logic        en8 = 1'b0;
  logic        cfg8_valid = 1'b0;
  logic        cfg8_ready;
  logic [7:0]  cfg8_int = '0;
  logic [3:0]  cfg8_frac = '0;
  logic        cfg8_err;
  logic        s8_tick;
  logic        b8_tick;
  logic        m8_tick;

  uart_baud_gen_frac u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sync_clr     (sync_clr),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_err      (cfg_err),
    .sample_tick  (sample_tick),
    .bit_tick     (bit_tick),
    .mid_tick     (mid_tick)
  );

  uart_baud_gen_frac #(.DIV_W(8), .FRAC_W(4)) u_dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en8),
    .sync_clr     (1'b0),
    .cfg_valid    (cfg8_valid),
    .cfg_ready    (cfg8_ready),
    .cfg_div_int  (cfg8_int),
    .cfg_div_frac (cfg8_frac),
    .cfg_err      (cfg8_err),
    .sample_tick  (s8_tick),
    .bit_tick     (b8_tick),
    .mid_tick     (m8_tick)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [31:0] exp_s_q[$];
  logic [31:0] exp_b_q[$];
  logic [31:0] exp_m_q[$];
  int obs_s[$];
  int obs8[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected tick at edge %0d, expected none", name, edge_n);
  endtask

  function automatic int tick_time(input int base, input int di, input int df,
                                   input int acc0, input int n);
    return base + n * di + (acc0 + n * df) / FRAC_ONE;
  endfunction

  task automatic expect_segment(input int base, input int di, input int df,
                                input int acc0, input int os0, input int ntick,
                                output int last);
    int t;
    last = base;
    for (int n = 1; n <= ntick; n++) begin
      t = tick_time(base, di, df, acc0, n);
      exp_s_q.push_back(32'(t));
      if ((os0 + n) % OS == 0) exp_b_q.push_back(32'(t));
      if ((os0 + n) % OS == OS / 2) exp_m_q.push_back(32'(t));
      last = t;
    end
  endtask

  task automatic drained(input string name);
    check({name, "_sample_left"}, exp_s_q.size(), 0);
    check({name, "_bit_left"}, exp_b_q.size(), 0);
    check({name, "_mid_left"}, exp_m_q.size(), 0);
    exp_s_q.delete();
    exp_b_q.delete();
    exp_m_q.delete();
  endtask

  // One clock: advance past the edge, then sample outputs.
  task automatic step();
    logic [31:0] e;
    @(posedge clk);
    #1;
    edge_n++;
    if (sample_tick === 1'b1) begin
      obs_s.push_back(edge_n);
      if (exp_s_q.size() == 0) unexpected("sample_tick");
      else begin
        e = exp_s_q.pop_front();
        check("sample_tick_edge", edge_n, int'(e));
      end
    end
    if (bit_tick === 1'b1) begin
      if (exp_b_q.size() == 0) unexpected("bit_tick");
      else begin
        e = exp_b_q.pop_front();
        check("bit_tick_edge", edge_n, int'(e));
      end
    end
    if (mid_tick === 1'b1) begin
      if (exp_m_q.size() == 0) unexpected("mid_tick");
      else begin
        e = exp_m_q.pop_front();
        check("mid_tick_edge", edge_n, int'(e));
      end
    end
    if (s8_tick === 1'b1) obs8.push_back(edge_n);
  endtask

  task automatic run_until(input int t);
    while (edge_n < t) step();
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    en = 1'b0;
    en8 = 1'b0;
    sync_clr = 1'b0;
    cfg_valid = 1'b0;
    cfg8_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_s_q.delete();
    exp_b_q.delete();
    exp_m_q.delete();
    obs_s.delete();
  endtask

  // Offers a divisor for one edge. The caller knows cfg_ready is high.
  task automatic send_cfg(input int di, input int df);
    cfg_div_int  = 16'(di);
    cfg_div_frac = 4'(df);
    cfg_valid    = 1'b1;
    step();
    cfg_valid    = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    baud_div_t div;
    int        exp_t1;
    int        exp_t16;
    int        exp_t32;
  } vec_t;

  vec_t vecs[6];

  task automatic set_vec(input int i, input int di, input int df,
                         input int t1, input int t16, input int t32);
    vecs[i].div.div_int  = 16'(di);
    vecs[i].div.div_frac = 4'(df);
    vecs[i].exp_t1       = t1;
    vecs[i].exp_t16      = t16;
    vecs[i].exp_t32      = t32;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int b;
    int last;
    int di;
    int df;

    set_vec(0, 54, 4,  54, 868, 1736);
    set_vec(1, 10, 0,  10, 160, 320);
    set_vec(2, 3,  8,  3,  56,  112);
    set_vec(3, 2,  15, 2,  47,  94);
    set_vec(4, 7,  1,  7,  113, 226);
    set_vec(5, 20, 12, 20, 332, 664);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_sample_tick", int'(sample_tick), 0);
    check("reset_bit_tick", int'(bit_tick), 0);
    check("reset_mid_tick", int'(mid_tick), 0);
    check("reset_cfg_err", int'(cfg_err), 0);
    check("reset_cfg_ready", int'(cfg_ready), 1);
    step();
    rst_n = 1'b1;
    step();

    // Default divisor 54.4/16 straight out of reset
    en = 1'b1;
    b = edge_n;
    obs_s.delete();
    expect_segment(b, 54, 4, 0, 0, 16, last);
    run_until(last);
    drained("default");
    if (obs_s.size() == 16) begin
      check("default_t1", obs_s[0] - b, 54);
      check("default_t16", obs_s[15] - b, 868);
    end else check("default_tick_count", obs_s.size(), 16);

    // Table: divisor programmed while disabled, then 32 ticks
    for (int i = 0; i < 6; i++) begin
      do_reset();
      send_cfg(int'(vecs[i].div.div_int), int'(vecs[i].div.div_frac));
      check("tbl_ready_low", int'(cfg_ready), 0);
      step();
      check("tbl_ready_back", int'(cfg_ready), 1);
      en = 1'b1;
      b = edge_n;
      obs_s.delete();
      expect_segment(b, int'(vecs[i].div.div_int), int'(vecs[i].div.div_frac),
                     0, 0, 32, last);
      run_until(last);
      drained("tbl");
      check("tbl_tick_count", obs_s.size(), 32);
      if (obs_s.size() == 32) begin
        check("tbl_t1", obs_s[0] - b, vecs[i].exp_t1);
        check("tbl_t16", obs_s[15] - b, vecs[i].exp_t16);
        check("tbl_t32", obs_s[31] - b, vecs[i].exp_t32);
      end
    end

    // Live reconfiguration to 10.0 inside the second period
    do_reset();
    en = 1'b1;
    b = edge_n;
    expect_segment(b, 54, 4, 0, 0, 2, last);
    run_until(b + 99);
    check("live_ready_before", int'(cfg_ready), 1);
    send_cfg(10, 0);
    check("live_ready_after_xfer", int'(cfg_ready), 0);
    run_until(b + 108);
    check("live_ready_at_boundary", int'(cfg_ready), 0);
    step();
    check("live_ready_returns", int'(cfg_ready), 1);
    expect_segment(b + 108, 10, 0, 8, 2, 16, last);
    run_until(last);
    drained("live");

    // Illegal divisor: error pulse, ready stays high, timing unchanged
    do_reset();
    en = 1'b1;
    b = edge_n;
    expect_segment(b, 54, 4, 0, 0, 16, last);
    run_until(b + 30);
    send_cfg(1, 0);
    check("illegal_err_pulse", int'(cfg_err), 1);
    check("illegal_ready_high", int'(cfg_ready), 1);
    step();
    check("illegal_err_clears", int'(cfg_err), 0);
    run_until(last);
    drained("illegal");

    // sync_clr on the edge where tick 3 is due
    do_reset();
    en = 1'b1;
    b = edge_n;
    expect_segment(b, 54, 4, 0, 0, 2, last);
    run_until(b + 161);
    drained("pre_sync");
    sync_clr = 1'b1;
    b = edge_n;
    expect_segment(b, 54, 4, 0, 0, 16, last);
    step();
    sync_clr = 1'b0;
    run_until(last);
    drained("sync_clr");

    // sync_clr while disabled does nothing extra
    do_reset();
    step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    step();
    check("sync_en_low_ready", int'(cfg_ready), 1);
    en = 1'b1;
    b = edge_n;
    expect_segment(b, 54, 4, 0, 0, 16, last);
    run_until(last);
    drained("sync_en_low");

    // Asynchronous reset with a pending divisor, right after a tick
    do_reset();
    en = 1'b1;
    b = edge_n;
    expect_segment(b, 54, 4, 0, 0, 2, last);
    run_until(b + 60);
    send_cfg(10, 0);
    check("rst_ready_pending", int'(cfg_ready), 0);
    run_until(b + 108);
    check("rst_tick_before", int'(sample_tick), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_sample", int'(sample_tick), 0);
    check("rst_async_bit", int'(bit_tick), 0);
    check("rst_async_mid", int'(mid_tick), 0);
    check("rst_async_ready", int'(cfg_ready), 1);
    step();
    step();
    #2 rst_n = 1'b1;
    b = edge_n;
    expect_segment(b, 54, 4, 0, 0, 16, last);
    run_until(last);
    drained("rst_restart");

    // Randomized divisors against the closed-form model
    for (int r = 0; r < 6; r++) begin
      do_reset();
      di = $urandom_range(2, 30);
      df = $urandom_range(0, 15);
      send_cfg(di, df);
      step();
      step();
      en = 1'b1;
      b = edge_n;
      expect_segment(b, di, df, 0, 0, 32, last);
      run_until(last);
      drained("random");
    end

    // Full-width period: 255 + carry gives 256 cycles on an 8-bit divider
    do_reset();
    cfg8_int   = 8'd255;
    cfg8_frac  = 4'd15;
    cfg8_valid = 1'b1;
    step();
    cfg8_valid = 1'b0;
    step();
    step();
    check("w8_ready", int'(cfg8_ready), 1);
    en8 = 1'b1;
    b = edge_n;
    obs8.delete();
    run_until(b + 767);
    check("w8_tick_count", obs8.size(), 3);
    if (obs8.size() == 3) begin
      check("w8_t1", obs8[0] - b, 255);
      check("w8_gap2", obs8[1] - obs8[0], 256);
      check("w8_gap3", obs8[2] - obs8[1], 256);
    end
    en8 = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
